// File: rtl/systolic_array_pkg.sv
// Shared types for the systolic-array subsystem, including the scratchpad sweep states.
// Scratchpad read forwarding is selected by the SCRATCHPAD_FWD_EN macro.
package systolic_array_pkg;

    typedef logic [31:0] word_t;

    typedef enum logic {
        INIT  = 1'b0,
        READY = 1'b1
    } sp_state_t;

    localparam int SP_DEPTH = 1024;

endpackage

// File: rtl/scratchpad_rd_port.sv
// One registered scratchpad read port: range check, index extract, optional write forwarding.
// Forwarding from same-cycle writes is compiled in only when SCRATCHPAD_FWD_EN is defined.
module scratchpad_rd_port
    import systolic_array_pkg::*;
#(
    parameter  int N     = 4,
    parameter  int DEPTH = SP_DEPTH,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic                  clk,
    input  logic                  n_rst,
    input  logic                  en_i,
    input  word_t                 addr_i,
    output logic [AW-1:0]         idx_o,
    input  word_t                 mem_data_i,
    input  logic [N-1:0]          wr_en_i,
    input  logic [N-1:0][AW-1:0]  wr_idx_i,
    input  logic [N-1:0][31:0]    wr_data_i,
    output word_t                 data_o,
    output logic                  err_o
);

    logic  oor;
    word_t data_q, data_d, rd_word;

    assign idx_o = addr_i[AW-1:0];
    assign oor   = |addr_i[31:AW];
    assign err_o = en_i & oor;

`ifdef SCRATCHPAD_FWD_EN
    // Ascending scan so the highest writing lane overrides lower ones.
    always_comb begin
        rd_word = mem_data_i;
        for (int j = 0; j < N; j++) begin
            if (wr_en_i[j] && (wr_idx_i[j] == idx_o)) begin
                rd_word = wr_data_i[j];
            end
        end
    end
`else
    logic unused_fwd;
    assign unused_fwd = ^{wr_en_i, wr_idx_i, wr_data_i};
    assign rd_word    = mem_data_i;
`endif

    always_comb begin
        data_d = data_q;
        if (en_i) begin
            data_d = oor ? '0 : rd_word;
        end
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            data_q <= '0;
        end else begin
            data_q <= data_d;
        end
    end

    assign data_o = data_q;

endmodule

// File: rtl/scratchpad_mem.sv
// N-lane scratchpad: 2N read ports, N write ports, self-clearing sweep after reset.
// Define SCRATCHPAD_FWD_EN to forward same-cycle write data to reads of the same index.
module scratchpad_mem
    import systolic_array_pkg::*;
#(
    parameter int N     = 4,
    parameter int DEPTH = SP_DEPTH
) (
    input  logic               clk,
    input  logic               n_rst,
    input  logic [N-1:0]       sc_valid_queue,
    input  logic [N-1:0][31:0] sc_x_queue,
    input  logic [N-1:0][31:0] sc_w_queue,
    output logic [N-1:0][31:0] sc_x_data,
    output logic [N-1:0][31:0] sc_w_data,
    input  logic [N-1:0]       sc_valid_write,
    input  logic [N-1:0][31:0] sc_write_queue,
    input  logic [N-1:0][31:0] sc_write_data,
    output logic               sc_ready,
    output logic               sc_err
);

    localparam int AW = $clog2(DEPTH);

    word_t               mem_q [DEPTH];
    sp_state_t           state_q, state_d;
    logic [AW-1:0]       cnt_q, cnt_d;
    logic                err_q, err_d;
    logic                ready;
    logic [N-1:0]        rd_en, wr_en, wr_oor, x_err, w_err;
    logic [N-1:0][AW-1:0] wr_idx, x_idx, w_idx;

    assign ready = (state_q == READY);

    always_comb begin
        for (int i = 0; i < N; i++) begin
            wr_idx[i] = sc_write_queue[i][AW-1:0];
            wr_oor[i] = |sc_write_queue[i][31:AW];
            wr_en[i]  = ready & sc_valid_write[i] & ~wr_oor[i];
            rd_en[i]  = ready & sc_valid_queue[i];
        end
    end

    for (genvar g = 0; g < N; g++) begin : g_lane
        scratchpad_rd_port #(.N(N), .DEPTH(DEPTH)) u_x_port (
            .clk        (clk),
            .n_rst      (n_rst),
            .en_i       (rd_en[g]),
            .addr_i     (sc_x_queue[g]),
            .idx_o      (x_idx[g]),
            .mem_data_i (mem_q[x_idx[g]]),
            .wr_en_i    (wr_en),
            .wr_idx_i   (wr_idx),
            .wr_data_i  (sc_write_data),
            .data_o     (sc_x_data[g]),
            .err_o      (x_err[g])
        );
        scratchpad_rd_port #(.N(N), .DEPTH(DEPTH)) u_w_port (
            .clk        (clk),
            .n_rst      (n_rst),
            .en_i       (rd_en[g]),
            .addr_i     (sc_w_queue[g]),
            .idx_o      (w_idx[g]),
            .mem_data_i (mem_q[w_idx[g]]),
            .wr_en_i    (wr_en),
            .wr_idx_i   (wr_idx),
            .wr_data_i  (sc_write_data),
            .data_o     (sc_w_data[g]),
            .err_o      (w_err[g])
        );
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        err_d   = err_q;
        case (state_q)
            INIT: begin
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == AW'(DEPTH - 1)) begin
                    state_d = READY;
                end
            end
            READY: begin
                if ((|x_err) || (|w_err) || (|(sc_valid_write & wr_oor))) begin
                    err_d = 1'b1;
                end
            end
            default: state_d = INIT;
        endcase
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state_q <= INIT;
            cnt_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
        end
    end

    // Array has no reset; the sweep clears it. Later lanes override earlier ones.
    always_ff @(posedge clk) begin
        if (state_q == INIT) begin
            mem_q[cnt_q] <= '0;
        end else begin
            for (int i = 0; i < N; i++) begin
                if (wr_en[i]) begin
                    mem_q[wr_idx[i]] <= sc_write_data[i];
                end
            end
        end
    end

    assign sc_ready = ready;
    assign sc_err   = err_q;

endmodule

// File: tb/tb_scratchpad_mem.sv
// Directed bench for scratchpad_mem; expected values are hand-computed constants.
module tb_scratchpad_mem;

    localparam int N     = 4;
    localparam int DEPTH = 64;

    logic               clk;
    logic               n_rst;
    logic [N-1:0]       sc_valid_queue;
    logic [N-1:0][31:0] sc_x_queue;
    logic [N-1:0][31:0] sc_w_queue;
    logic [N-1:0][31:0] sc_x_data;
    logic [N-1:0][31:0] sc_w_data;
    logic [N-1:0]       sc_valid_write;
    logic [N-1:0][31:0] sc_write_queue;
    logic [N-1:0][31:0] sc_write_data;
    logic               sc_ready;
    logic               sc_err;

    int errors = 0;
    int checks = 0;

    scratchpad_mem #(.N(N), .DEPTH(DEPTH)) dut (
        .clk            (clk),
        .n_rst          (n_rst),
        .sc_valid_queue (sc_valid_queue),
        .sc_x_queue     (sc_x_queue),
        .sc_w_queue     (sc_w_queue),
        .sc_x_data      (sc_x_data),
        .sc_w_data      (sc_w_data),
        .sc_valid_write (sc_valid_write),
        .sc_write_queue (sc_write_queue),
        .sc_write_data  (sc_write_data),
        .sc_ready       (sc_ready),
        .sc_err         (sc_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        sc_valid_queue = '0;
        sc_x_queue     = '0;
        sc_w_queue     = '0;
        sc_valid_write = '0;
        sc_write_queue = '0;
        sc_write_data  = '0;
    endtask

    // Releases reset and counts edges until ready; returns the count (or -1 on timeout).
    task automatic release_and_wait(output int cycles);
        n_rst  = 1'b1;
        cycles = -1;
        for (int k = 1; k <= DEPTH + 8; k++) begin
            tick();
            if (sc_ready) begin
                cycles = k;
                break;
            end
        end
    endtask

    task automatic test_reset();
        int cyc;
        idle();
        n_rst = 1'b0;
        repeat (3) tick();
        checks++;
        if (sc_ready !== 1'b0 || sc_err !== 1'b0 || sc_x_data !== '0 || sc_w_data !== '0) begin
            errors++;
            $display("FAIL reset_values: ready=%b err=%b x=%h w=%h required all zero",
                     sc_ready, sc_err, sc_x_data, sc_w_data);
        end
        release_and_wait(cyc);
        checks++;
        if (cyc !== DEPTH) begin
            errors++;
            $display("FAIL ready_latency: got %0d cycles required %0d", cyc, DEPTH);
        end
    endtask

    task automatic test_clear_readback();
        int bad = 0;
        for (int a = 0; a < DEPTH; a += 2 * N) begin
            for (int l = 0; l < N; l++) begin
                sc_valid_queue[l] = 1'b1;
                sc_x_queue[l]     = 32'(a + 2 * l);
                sc_w_queue[l]     = 32'(a + 2 * l + 1);
            end
            tick();
            if (sc_x_data !== '0 || sc_w_data !== '0) bad++;
        end
        idle();
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL clear_readback: %0d nonzero read groups required 0", bad);
        end
    endtask

    task automatic test_write_read_hold();
        sc_valid_write[2] = 1'b1;
        sc_write_queue[2] = 32'h10;
        sc_write_data[2]  = 32'hDEADBEEF;
        tick();
        idle();
        sc_valid_queue[0] = 1'b1;
        sc_x_queue[0]     = 32'h10;
        sc_w_queue[0]     = 32'h11;
        tick();
        idle();
        checks++;
        if (sc_x_data[0] !== 32'hDEADBEEF || sc_w_data[0] !== 32'h0) begin
            errors++;
            $display("FAIL write_then_read: x=%h w=%h required deadbeef 00000000",
                     sc_x_data[0], sc_w_data[0]);
        end
        repeat (3) tick();
        checks++;
        if (sc_x_data[0] !== 32'hDEADBEEF) begin
            errors++;
            $display("FAIL read_hold: x=%h required deadbeef", sc_x_data[0]);
        end
    endtask

    task automatic test_write_priority();
        sc_valid_write    = 4'b1011;
        sc_write_queue[0] = 32'd5;
        sc_write_data[0]  = 32'h1;
        sc_write_queue[1] = 32'd6;
        sc_write_data[1]  = 32'h66;
        sc_write_queue[3] = 32'd5;
        sc_write_data[3]  = 32'h3;
        tick();
        idle();
        sc_valid_queue[1] = 1'b1;
        sc_x_queue[1]     = 32'd5;
        sc_w_queue[1]     = 32'd6;
        tick();
        idle();
        checks++;
        if (sc_x_data[1] !== 32'h3 || sc_w_data[1] !== 32'h66) begin
            errors++;
            $display("FAIL write_priority: x=%h w=%h required 00000003 00000066",
                     sc_x_data[1], sc_w_data[1]);
        end
    endtask

    task automatic test_same_cycle();
        logic [31:0] exp7, exp9;
`ifdef SCRATCHPAD_FWD_EN
        exp7 = 32'hAA;
        exp9 = 32'h33;
`else
        exp7 = 32'h55;
        exp9 = 32'h0;
`endif
        sc_valid_write[0] = 1'b1;
        sc_write_queue[0] = 32'd7;
        sc_write_data[0]  = 32'h55;
        tick();
        idle();
        sc_valid_write    = 4'b1011;
        sc_write_queue[0] = 32'd7;
        sc_write_data[0]  = 32'hAA;
        sc_write_queue[1] = 32'd9;
        sc_write_data[1]  = 32'h11;
        sc_write_queue[3] = 32'd9;
        sc_write_data[3]  = 32'h33;
        sc_valid_queue[2] = 1'b1;
        sc_x_queue[2]     = 32'd7;
        sc_w_queue[2]     = 32'd9;
        tick();
        idle();
        checks++;
        if (sc_x_data[2] !== exp7 || sc_w_data[2] !== exp9) begin
            errors++;
            $display("FAIL same_cycle_rw: x=%h w=%h required %h %h",
                     sc_x_data[2], sc_w_data[2], exp7, exp9);
        end
        sc_valid_queue[2] = 1'b1;
        sc_x_queue[2]     = 32'd7;
        sc_w_queue[2]     = 32'd9;
        tick();
        idle();
        checks++;
        if (sc_x_data[2] !== 32'hAA || sc_w_data[2] !== 32'h33) begin
            errors++;
            $display("FAIL after_same_cycle: x=%h w=%h required 000000aa 00000033",
                     sc_x_data[2], sc_w_data[2]);
        end
        checks++;
        if (sc_err !== 1'b0) begin
            errors++;
            $display("FAIL err_clean: err=%b required 0", sc_err);
        end
    endtask

    task automatic test_out_of_range();
        sc_valid_write[1] = 1'b1;
        sc_write_queue[1] = 32'd0;
        sc_write_data[1]  = 32'h1234;
        tick();
        idle();
        sc_valid_queue[3] = 1'b1;
        sc_x_queue[3]     = 32'd0;
        sc_w_queue[3]     = 32'd0;
        tick();
        idle();
        sc_valid_queue[3] = 1'b1;
        sc_x_queue[3]     = 32'(DEPTH + 4);
        sc_w_queue[3]     = 32'd0;
        tick();
        idle();
        checks++;
        if (sc_x_data[3] !== 32'h0 || sc_w_data[3] !== 32'h1234 || sc_err !== 1'b1) begin
            errors++;
            $display("FAIL oor_read: x=%h w=%h err=%b required 00000000 00001234 1",
                     sc_x_data[3], sc_w_data[3], sc_err);
        end
        repeat (10) tick();
        checks++;
        if (sc_err !== 1'b1) begin
            errors++;
            $display("FAIL err_sticky: err=%b required 1", sc_err);
        end
        sc_valid_write[0] = 1'b1;
        sc_write_queue[0] = 32'(DEPTH);
        sc_write_data[0]  = 32'hBAD;
        tick();
        idle();
        sc_valid_queue[0] = 1'b1;
        sc_x_queue[0]     = 32'd0;
        sc_w_queue[0]     = 32'd0;
        tick();
        idle();
        checks++;
        if (sc_x_data[0] !== 32'h1234) begin
            errors++;
            $display("FAIL oor_write_dropped: mem0=%h required 00001234", sc_x_data[0]);
        end
    endtask

    task automatic test_reset_mid();
        int cyc;
        sc_valid_queue[0] = 1'b1;
        sc_x_queue[0]     = 32'd0;
        sc_w_queue[0]     = 32'd0;
        tick();
        n_rst = 1'b0;
        #1;
        checks++;
        if (sc_x_data !== '0 || sc_w_data !== '0 || sc_ready !== 1'b0 || sc_err !== 1'b0) begin
            errors++;
            $display("FAIL reset_mid_traffic: x=%h w=%h ready=%b err=%b required all zero",
                     sc_x_data, sc_w_data, sc_ready, sc_err);
        end
        idle();
        tick();
        n_rst = 1'b1;
        repeat (10) tick();
        n_rst = 1'b0;
        #1;
        checks++;
        if (sc_ready !== 1'b0) begin
            errors++;
            $display("FAIL reset_mid_sweep: ready=%b required 0", sc_ready);
        end
        tick();
        // Traffic during the sweep must be ignored entirely.
        sc_valid_queue[0] = 1'b1;
        sc_x_queue[0]     = 32'd0;
        sc_w_queue[0]     = 32'(DEPTH + 1);
        sc_valid_write    = 4'b0011;
        sc_write_queue[0] = 32'd3;
        sc_write_data[0]  = 32'h77;
        sc_write_queue[1] = 32'(DEPTH + 2);
        sc_write_data[1]  = 32'h99;
        release_and_wait(cyc);
        checks++;
        if (cyc !== DEPTH) begin
            errors++;
            $display("FAIL ready_after_resweep: got %0d cycles required %0d", cyc, DEPTH);
        end
        checks++;
        if (sc_err !== 1'b0 || sc_x_data[0] !== 32'h0 || sc_w_data[0] !== 32'h0) begin
            errors++;
            $display("FAIL init_ignores_traffic: err=%b x=%h w=%h required 0 0 0",
                     sc_err, sc_x_data[0], sc_w_data[0]);
        end
        idle();
        sc_valid_queue[1] = 1'b1;
        sc_x_queue[1]     = 32'd3;
        sc_w_queue[1]     = 32'h10;
        tick();
        idle();
        checks++;
        if (sc_x_data[1] !== 32'h0 || sc_w_data[1] !== 32'h0) begin
            errors++;
            $display("FAIL resweep_cleared: x=%h w=%h required 0 0", sc_x_data[1], sc_w_data[1]);
        end
        sc_valid_write[2] = 1'b1;
        sc_write_queue[2] = 32'h8000_0000;
        sc_write_data[2]  = 32'h5;
        tick();
        idle();
        checks++;
        if (sc_err !== 1'b1) begin
            errors++;
            $display("FAIL oor_write_err: err=%b required 1", sc_err);
        end
    endtask

    initial begin
        n_rst = 1'b0;
        idle();
        test_reset();
        test_clear_readback();
        test_write_read_hold();
        test_write_priority();
        test_same_cycle();
        test_out_of_range();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
